// File: rtl/vend_sequencer.sv
// ----------------------------------------------------------------------------
// vend_sequencer
//   Runs one vend transaction. Coin pulses from the debounced coin slot add
//   credit in nickel units. Once the stored credit reaches PRICE, the block
//   asks the soda dispenser for one soda. It then pays out any remainder one
//   nickel at a time through the change dispenser. Both dispensers use a
//   level request and a one-cycle acknowledge pulse.
//
// Optional feature (compile-time macro VEND_TIMEOUT_EN):
//   When defined, a watchdog counts the cycles a request stays high without
//   an ack. After ACK_TIMEOUT such cycles the block enters FAULT: both
//   requests drop, o_fault sets and stays set, the credit stays frozen, and
//   every coin is rejected. Only i_rst leaves FAULT.
//   When undefined, requests wait for an ack indefinitely, FAULT cannot be
//   reached, and o_fault is always 0.
//
// Parameters:
//   PRICE        soda price in nickels (1..15)
//   CREDIT_W     credit width; must hold PRICE-1+5
//   ACK_TIMEOUT  ack watchdog limit in cycles (VEND_TIMEOUT_EN only)
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst          synchronous reset, active-high
//   i_nickle       1-cycle coin pulse, value 1
//   i_dime         1-cycle coin pulse, value 2
//   i_quarter      1-cycle coin pulse, value 5
//   o_coin_reject  1-cycle pulse: coin returned, credit unchanged
//   o_soda_req     dispense-soda request (level)
//   i_soda_ack     soda dispensed (1-cycle pulse)
//   o_chg_req      dispense-one-nickel request (level)
//   i_chg_ack      one nickel dispensed (1-cycle pulse)
//   o_credit       current credit in nickels
//   o_busy         high whenever the state is not COLLECT
//   o_fault        dispenser timeout, sticky until reset
// ----------------------------------------------------------------------------
module vend_sequencer #(
  parameter int PRICE       = 4,
  parameter int CREDIT_W    = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_nickle,
  input  logic                i_dime,
  input  logic                i_quarter,
  output logic                o_coin_reject,
  output logic                o_soda_req,
  input  logic                i_soda_ack,
  output logic                o_chg_req,
  input  logic                i_chg_ack,
  output logic [CREDIT_W-1:0] o_credit,
  output logic                o_busy,
  output logic                o_fault
);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_VEND    = 2'd1,
    ST_CHANGE  = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  state_t              r_state;
  state_t              w_next_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] w_next_credit;
  logic                r_coin_reject;
  logic                r_soda_req;
  logic                r_chg_req;
  logic                r_busy;
  logic                r_fault;

  logic [1:0]          w_coin_cnt;
  logic                w_any_coin;
  logic                w_one_coin;
  logic [CREDIT_W-1:0] w_coin_val;
  logic                w_reject;
  logic                w_soda_ack;
  logic                w_chg_ack;
  logic                w_tmo_hit;
  logic [CREDIT_W-1:0] w_credit_after_vend;
  logic [CREDIT_W-1:0] w_credit_after_chg;

  // Coin decode: how many coin inputs are high, and the value of a lone coin.
  always_comb begin
    w_coin_cnt = {1'b0, i_nickle} + {1'b0, i_dime} + {1'b0, i_quarter};
    w_any_coin = (w_coin_cnt != 2'd0);
    w_one_coin = (w_coin_cnt == 2'd1);
    if (i_quarter) begin
      w_coin_val = CREDIT_W'(5);
    end else if (i_dime) begin
      w_coin_val = CREDIT_W'(2);
    end else if (i_nickle) begin
      w_coin_val = CREDIT_W'(1);
    end else begin
      w_coin_val = CREDIT_W'(0);
    end
  end

  // An ack is honoured only while its request is actually being driven.
  assign w_soda_ack = i_soda_ack & r_soda_req;
  assign w_chg_ack  = i_chg_ack & r_chg_req;

  assign w_credit_after_vend = r_credit - PRICE_C;
  assign w_credit_after_chg  = r_credit - CREDIT_W'(1);

`ifdef VEND_TIMEOUT_EN
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  logic [TMO_W-1:0] r_tmo_cnt;

  // The watchdog fires in the cycle that would be the ACK_TIMEOUT-th
  // consecutive request cycle without an ack.
  assign w_tmo_hit = (r_tmo_cnt == TMO_W'(ACK_TIMEOUT - 1));

  // Ack watchdog: counts request-high cycles and restarts on any ack or state change.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tmo_cnt <= TMO_W'(0);
    end else if ((w_next_state != r_state) || w_soda_ack || w_chg_ack) begin
      r_tmo_cnt <= TMO_W'(0);
    end else if (r_soda_req || r_chg_req) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end else begin
      r_tmo_cnt <= TMO_W'(0);
    end
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  // Next-state, next-credit and coin-reject decision for the transaction FSM.
  always_comb begin
    w_next_state  = r_state;
    w_next_credit = r_credit;
    w_reject      = w_any_coin;
    case (r_state)
      ST_COLLECT: begin
        if (r_credit >= PRICE_C) begin
          // Price already met: start the vend. A coin in this cycle is returned.
          w_next_state = ST_VEND;
        end else if (w_one_coin) begin
          w_next_credit = r_credit + w_coin_val;
          w_reject      = 1'b0;
        end else begin
          // Either no coin, or several at once (returned by the default).
          w_next_credit = r_credit;
        end
      end
      ST_VEND: begin
        if (w_soda_ack) begin
          w_next_credit = w_credit_after_vend;
          if (w_credit_after_vend != CREDIT_W'(0)) begin
            w_next_state = ST_CHANGE;
          end else begin
            w_next_state = ST_COLLECT;
          end
        end else if (w_tmo_hit) begin
          w_next_state = ST_FAULT;
        end else begin
          w_next_state = ST_VEND;
        end
      end
      ST_CHANGE: begin
        if (w_chg_ack) begin
          w_next_credit = w_credit_after_chg;
          if (w_credit_after_chg == CREDIT_W'(0)) begin
            w_next_state = ST_COLLECT;
          end else begin
            w_next_state = ST_CHANGE;
          end
        end else if (w_tmo_hit) begin
          w_next_state = ST_FAULT;
        end else begin
          w_next_state = ST_CHANGE;
        end
      end
      ST_FAULT: begin
        // Hold the frozen credit until reset.
        w_next_state = ST_FAULT;
      end
      default: begin
        w_next_state  = ST_COLLECT;
        w_next_credit = CREDIT_W'(0);
      end
    endcase
  end

  // State, credit and every output are registered. Outputs are decoded from
  // the next state, so they change on the same edge as the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_COLLECT;
      r_credit      <= CREDIT_W'(0);
      r_coin_reject <= 1'b0;
      r_soda_req    <= 1'b0;
      r_chg_req     <= 1'b0;
      r_busy        <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_credit      <= w_next_credit;
      r_coin_reject <= w_reject;
      r_soda_req    <= (w_next_state == ST_VEND);
      r_chg_req     <= (w_next_state == ST_CHANGE);
      r_busy        <= (w_next_state != ST_COLLECT);
      r_fault       <= (w_next_state == ST_FAULT);
    end
  end

  assign o_coin_reject = r_coin_reject;
  assign o_soda_req    = r_soda_req;
  assign o_chg_req     = r_chg_req;
  assign o_credit      = r_credit;
  assign o_busy        = r_busy;
  assign o_fault       = r_fault;

endmodule

// File: tb/tb_vend_sequencer.sv
// ----------------------------------------------------------------------------
// tb_vend_sequencer
//   Directed-vector bench for vend_sequencer with the default parameters
//   (PRICE=4, CREDIT_W=4, ACK_TIMEOUT=15). Inputs change 1 ns after a rising
//   edge, and outputs are sampled at that same point.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vend_sequencer;

  logic       clk;
  logic       rst;
  logic       nickle;
  logic       dime;
  logic       quarter;
  logic       coin_reject;
  logic       soda_req;
  logic       soda_ack;
  logic       chg_req;
  logic       chg_ack;
  logic [3:0] credit;
  logic       busy;
  logic       fault;

  int checks_s;
  int failures_s;
  logic chg_seen_s;

  vend_sequencer #(
    .PRICE       (4),
    .CREDIT_W    (4),
    .ACK_TIMEOUT (15)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_nickle      (nickle),
    .i_dime        (dime),
    .i_quarter     (quarter),
    .o_coin_reject (coin_reject),
    .o_soda_req    (soda_req),
    .i_soda_ack    (soda_ack),
    .o_chg_req     (chg_req),
    .i_chg_ack     (chg_ack),
    .o_credit      (credit),
    .o_busy        (busy),
    .o_fault       (fault)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point for the whole bench.
  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_s = checks_s + 1;
    if (obs !== exp) begin
      failures_s = failures_s + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and stop 1 ns past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (chg_req === 1'b1) chg_seen_s = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Drive a single-cycle pulse on the selected coin inputs (mask: q,d,n).
  task automatic coin(input logic [2:0] qdn);
    quarter = qdn[2];
    dime    = qdn[1];
    nickle  = qdn[0];
    tick();
    quarter = 1'b0;
    dime    = 1'b0;
    nickle  = 1'b0;
  endtask

  task automatic soda_pulse();
    soda_ack = 1'b1;
    tick();
    soda_ack = 1'b0;
  endtask

  task automatic chg_pulse();
    chg_ack = 1'b1;
    tick();
    chg_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    checks_s   = 0;
    failures_s = 0;
    chg_seen_s = 1'b0;
    rst        = 1'b0;
    nickle     = 1'b0;
    dime       = 1'b0;
    quarter    = 1'b0;
    soda_ack   = 1'b0;
    chg_ack    = 1'b0;
    #2;

    // Reset state.
    do_reset();
    chk_eq("rst_credit", 32'(credit), 32'd0);
    chk_eq("rst_soda",   32'(soda_req), 32'd0);
    chk_eq("rst_chg",    32'(chg_req), 32'd0);
    chk_eq("rst_busy",   32'(busy), 32'd0);
    chk_eq("rst_fault",  32'(fault), 32'd0);
    chk_eq("rst_rej",    32'(coin_reject), 32'd0);

    // 1. Quarter: credit 5, vend, one nickel change.
    coin(3'b100);
    chk_eq("t1_credit5", 32'(credit), 32'd5);
    chk_eq("t1_soda_c1", 32'(soda_req), 32'd0);
    chk_eq("t1_rej_c1",  32'(coin_reject), 32'd0);
    tick();
    chk_eq("t1_soda_c2", 32'(soda_req), 32'd1);
    chk_eq("t1_busy_c2", 32'(busy), 32'd1);
    ticks(3);
    chk_eq("t1_soda_hold", 32'(soda_req), 32'd1);
    soda_pulse();
    chk_eq("t1_credit1", 32'(credit), 32'd1);
    chk_eq("t1_soda_off", 32'(soda_req), 32'd0);
    chk_eq("t1_chg_on", 32'(chg_req), 32'd1);
    chg_pulse();
    chk_eq("t1_credit0", 32'(credit), 32'd0);
    chk_eq("t1_chg_off", 32'(chg_req), 32'd0);
    chk_eq("t1_busy_off", 32'(busy), 32'd0);

    // 2. Four nickels, exact price, no change.
    chg_seen_s = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      coin(3'b001);
      chk_eq("t2_credit_step", 32'(credit), 32'(k));
    end
    tick();
    chk_eq("t2_soda_on", 32'(soda_req), 32'd1);
    soda_pulse();
    chk_eq("t2_credit0", 32'(credit), 32'd0);
    chk_eq("t2_soda_off", 32'(soda_req), 32'd0);
    chk_eq("t2_busy_off", 32'(busy), 32'd0);
    tick();
    chk_eq("t2_no_chg", 32'(chg_seen_s), 32'd0);

    // 3. Dime + nickel in the same cycle are rejected.
    coin(3'b011);
    chk_eq("t3_reject", 32'(coin_reject), 32'd1);
    chk_eq("t3_credit", 32'(credit), 32'd0);
    tick();
    chk_eq("t3_reject_pulse", 32'(coin_reject), 32'd0);

    // 4. Coin while credit is already at the price, then a coin and a stray chg ack during VEND.
    coin(3'b010);
    coin(3'b010);
    chk_eq("t4_credit4", 32'(credit), 32'd4);
    coin(3'b001);
    chk_eq("t4_rej_at_price", 32'(coin_reject), 32'd1);
    chk_eq("t4_credit_hold", 32'(credit), 32'd4);
    chk_eq("t4_soda_on", 32'(soda_req), 32'd1);
    coin(3'b100);
    chk_eq("t4_rej_vend", 32'(coin_reject), 32'd1);
    chk_eq("t4_credit_vend", 32'(credit), 32'd4);
    chg_pulse();
    chk_eq("t4_stray_chg", 32'(credit), 32'd4);
    chk_eq("t4_soda_still", 32'(soda_req), 32'd1);
    soda_pulse();
    chk_eq("t4_credit0", 32'(credit), 32'd0);
    chk_eq("t4_busy_off", 32'(busy), 32'd0);

    // 5. Stray soda ack while idle, then reset in the middle of CHANGE.
    coin(3'b010);
    soda_pulse();
    chk_eq("t5_stray_soda", 32'(credit), 32'd2);
    chk_eq("t5_stray_busy", 32'(busy), 32'd0);
    coin(3'b100);
    chk_eq("t5_credit7", 32'(credit), 32'd7);
    tick();
    soda_pulse();
    chk_eq("t5_credit3", 32'(credit), 32'd3);
    chk_eq("t5_chg_on", 32'(chg_req), 32'd1);
    chg_pulse();
    chk_eq("t5_credit2", 32'(credit), 32'd2);
    chk_eq("t5_chg_hold", 32'(chg_req), 32'd1);
    chg_ack = 1'b1;
    do_reset();
    chg_ack = 1'b0;
    chk_eq("t5_rst_credit", 32'(credit), 32'd0);
    chk_eq("t5_rst_chg", 32'(chg_req), 32'd0);
    chk_eq("t5_rst_busy", 32'(busy), 32'd0);
    chk_eq("t5_rst_soda", 32'(soda_req), 32'd0);

    // 6. No soda ack for a long time.
    coin(3'b100);
    tick();
    chk_eq("t6_soda_on", 32'(soda_req), 32'd1);
`ifdef VEND_TIMEOUT_EN
    ticks(14);
    chk_eq("t6_pre_fault", 32'(fault), 32'd0);
    chk_eq("t6_pre_soda", 32'(soda_req), 32'd1);
    tick();
    chk_eq("t6_fault", 32'(fault), 32'd1);
    chk_eq("t6_soda_off", 32'(soda_req), 32'd0);
    chk_eq("t6_credit_frozen", 32'(credit), 32'd5);
    coin(3'b001);
    chk_eq("t6_reject", 32'(coin_reject), 32'd1);
    chk_eq("t6_credit_still", 32'(credit), 32'd5);
    soda_pulse();
    chk_eq("t6_fault_sticky", 32'(fault), 32'd1);
    do_reset();
    chk_eq("t6_rst_fault", 32'(fault), 32'd0);
    chk_eq("t6_rst_credit", 32'(credit), 32'd0);
`else
    ticks(40);
    chk_eq("t6_no_fault", 32'(fault), 32'd0);
    chk_eq("t6_soda_wait", 32'(soda_req), 32'd1);
    chk_eq("t6_credit_wait", 32'(credit), 32'd5);
    soda_pulse();
    chk_eq("t6_credit1", 32'(credit), 32'd1);
    chk_eq("t6_chg_on", 32'(chg_req), 32'd1);
    chg_pulse();
    chk_eq("t6_credit0", 32'(credit), 32'd0);
    chk_eq("t6_busy_off", 32'(busy), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks_s, failures_s);
    $finish;
  end

endmodule
